// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between instruction-fetch (IF) and data-memory (DM) ports
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_kill,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,

    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,

    output logic                o_mem_valid,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e              state_q,      state_d;
    owner_e              owner_q,      owner_d;
    logic                drop_q,       drop_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

    logic                mem_valid_q,  mem_valid_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,     mem_be_d;

    logic                if_rvalid_q,  if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic                dm_rvalid_q,  dm_rvalid_d;
    logic [DATA_W-1:0]   dm_rdata_q,   dm_rdata_d;

    logic                dm_wins;
    logic                if_kill_hit;

    // Arbitration decision, bus issue, kill tracking and response routing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rvalid_d  = 1'b0;
        dm_rdata_d   = dm_rdata_q;

        // DM carries the older instruction, but IF is forced through once
        // it has lost STARVE_MAX decisions in a row.
        dm_wins     = i_dm_req && (!i_if_req || (starve_cnt_q < STARVE_LIM));
        if_kill_hit = i_if_kill && (owner_q == OWN_IF);

        case (state_q)
            ST_IDLE: begin
                if (i_if_req || i_dm_req) begin
                    state_d     = ST_REQ;
                    mem_valid_d = 1'b1;
                    drop_d      = 1'b0;
                    if (dm_wins) begin
                        owner_d     = OWN_DM;
                        mem_we_d    = i_dm_we;
                        mem_addr_d  = i_dm_addr;
                        mem_wdata_d = i_dm_wdata;
                        mem_be_d    = i_dm_be;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                    if (dm_wins && i_if_req) begin
                        if (starve_cnt_q < STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end

            ST_REQ: begin
                if (if_kill_hit) begin
                    drop_d = 1'b1;
                end
                if (i_mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (if_kill_hit) begin
                    drop_d = 1'b1;
                end
                if (i_mem_rvalid) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = i_mem_rdata;
                    end else if (!(drop_q || if_kill_hit)) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = i_mem_rdata;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rvalid_q  <= 1'b0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rvalid_q  <= dm_rvalid_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Grants follow the bus handshake in the same cycle; held off while reset is asserted.
    always_comb begin
        o_if_gnt = !i_rst && (state_q == ST_REQ) && i_mem_ready && (owner_q == OWN_IF);
        o_dm_gnt = !i_rst && (state_q == ST_REQ) && i_mem_ready && (owner_q == OWN_DM);
    end

    assign o_mem_valid = mem_valid_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_if_rvalid = if_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_dm_rvalid = dm_rvalid_q;
    assign o_dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    bit          gnt_log[$];
    int          total = 0;
    int          bad = 0;
    bit          auto_mode = 1'b0;
    bit          auto_pend = 1'b0;
    logic [31:0] auto_addr = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
        .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_valid(mem_valid), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] model(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({mem_valid, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 64'(0));
        check({tag, "_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_wdata_be"}, 64'({mem_wdata, mem_be}), 64'(0));
        check({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'(0));
    endtask

    // Advance one clock; check any response against the scoreboard; run the auto bus responder.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #2;
        if (if_rvalid || dm_rvalid) begin
            check("rvalid_both", 64'(if_rvalid & dm_rvalid), 64'(0));
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 64'({dm_rvalid, if_rvalid}), 64'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_port", 64'(dm_rvalid), 64'(e.is_dm));
                check("rsp_data", 64'(e.is_dm ? dm_rdata : if_rdata), 64'(e.data));
            end
        end
        if (auto_mode) begin
            mem_rvalid = auto_pend;
            mem_rdata  = auto_pend ? model(auto_addr) : 32'h0;
            auto_pend  = 1'b0;
            mem_ready  = mem_valid;
            #1;
            if (mem_valid && (if_gnt || dm_gnt)) begin
                check("auto_addr", 64'(mem_addr), 64'(dm_gnt ? dm_addr : if_addr));
                gnt_log.push_back(dm_gnt);
                sb.push_back('{is_dm: dm_gnt, data: model(dm_gnt ? dm_addr : if_addr)});
                auto_pend = 1'b1;
                auto_addr = mem_addr;
            end
        end
    endtask

    initial begin
        bit exp_order[10];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // reset state
        step(); step();
        check_zero("reset");
        rst = 1'b0;
        step();
        check_zero("idle");

        // single IF read, minimum latency
        if_req = 1'b1; if_addr = 32'h100;
        step();
        check("if_mem_valid", 64'(mem_valid), 64'(1));
        check("if_mem_addr", 64'(mem_addr), 64'h100);
        check("if_mem_be_we", 64'({mem_be, mem_we}), 64'({4'hF, 1'b0}));
        check("if_mem_wdata", 64'(mem_wdata), 64'(0));
        mem_ready = 1'b1;
        #1;
        check("if_gnt", 64'({if_gnt, dm_gnt}), 64'(2'b10));
        step();
        check("if_gnt_once", 64'({if_gnt, mem_valid}), 64'(0));
        if_req = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        sb.push_back('{is_dm: 1'b0, data: 32'h0050_0093});
        step();
        check("if_rvalid_n3", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'h0050_0093}));
        mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        check("if_rvalid_pulse", 64'(if_rvalid), 64'(0));

        // DM store with three stalled cycles
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
        step();
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("st_mem_%0d", k), {mem_valid, mem_we, 2'b00, mem_be, 24'h0, mem_addr[7:0]},
                  {1'b1, 1'b1, 2'b00, 4'h3, 24'h0, 8'h00});
            check($sformatf("st_addr_wdata_%0d", k), {mem_addr, mem_wdata}, {32'h2000, 32'hDEAD_BEEF});
            mem_ready = (k == 4);
            #1;
            check($sformatf("st_gnt_%0d", k), 64'({dm_gnt, if_gnt}), 64'({(k == 4), 1'b0}));
            step();
        end
        dm_req = 1'b0; mem_ready = 1'b0;
        check("st_resp_wait", 64'({mem_valid, dm_rvalid}), 64'(0));
        mem_rvalid = 1'b1; mem_rdata = 32'h0;
        sb.push_back('{is_dm: 1'b1, data: 32'h0});
        step();
        check("st_ack", 64'(dm_rvalid), 64'(1));
        mem_rvalid = 1'b0;
        step();

        // both requesters held: DM x4, IF, DM x4, IF
        dm_we = 1'b0; dm_addr = 32'h44; dm_be = 4'hF; dm_wdata = '0;
        if_addr = 32'h300;
        if_req = 1'b1; dm_req = 1'b1;
        auto_mode = 1'b1;
        for (int c = 0; c < 300 && gnt_log.size() < 10; c++) begin
            step();
        end
        if_req = 1'b0; dm_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
        end
        auto_mode = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        check("arb_gnt_count", 64'(gnt_log.size()), 64'(10));
        for (int i = 0; i < 10; i++) begin
            if (i < gnt_log.size()) begin
                check($sformatf("arb_order_%0d", i), 64'(gnt_log[i]), 64'(exp_order[i]));
            end
        end
        check("arb_sb_drained", 64'(sb.size()), 64'(0));

        // IF kill during RESP, then a normal fetch
        if_req = 1'b1; if_addr = 32'h104;
        step();
        mem_ready = 1'b1;
        #1;
        check("kill_gnt", 64'(if_gnt), 64'(1));
        step();
        if_req = 1'b0; mem_ready = 1'b0; if_kill = 1'b1;
        step();
        if_kill = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        check("kill_no_rvalid", 64'({if_rvalid, dm_rvalid}), 64'(0));
        mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h108;
        step();
        check("kill_next_issue", 64'({mem_valid, mem_addr}), 64'({1'b1, 32'h108}));
        mem_ready = 1'b1;
        #1;
        check("kill_next_gnt", 64'(if_gnt), 64'(1));
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0113;
        sb.push_back('{is_dm: 1'b0, data: 32'h00A0_0113});
        step();
        check("kill_next_rvalid", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'h00A0_0113}));
        mem_rvalid = 1'b0;
        step();

        // reset mid-RESP followed by a spurious bus response
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        step();
        mem_ready = 1'b1;
        step();
        dm_req = 1'b0; mem_ready = 1'b0; rst = 1'b1;
        step();
        check_zero("rst_mid");
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        step();
        check_zero("spurious");
        mem_rvalid = 1'b0;
        step();
        check_zero("post_spurious");

        // DM load after reset
        dm_req = 1'b1; dm_addr = 32'h40; dm_be = 4'hF;
        step();
        check("ld_issue", 64'({mem_valid, mem_we, mem_addr}), 64'({1'b1, 1'b0, 32'h40}));
        mem_ready = 1'b1;
        #1;
        check("ld_gnt", 64'({dm_gnt, if_gnt}), 64'(2'b10));
        step();
        dm_req = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        sb.push_back('{is_dm: 1'b1, data: 32'hCAFE_F00D});
        step();
        check("ld_rvalid", 64'({dm_rvalid, dm_rdata}), 64'({1'b1, 32'hCAFE_F00D}));
        mem_rvalid = 1'b0;
        step();
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the CPU's single memory bus between the instruction-fetch port (IF, pipeline stage 1) and the data-memory port (DM, stage 4 load/store).
- Sequences one transaction at a time: arbitrate, issue with a valid/ready handshake, wait for the response, then route it back to the requester that owns it.
- DM has fixed priority over IF, because it carries the older instruction. A starvation counter bounds how long IF can wait.
- Sits between the pipeline's memory ports and the memory/bus interface.

## Interface

Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `STARVE_MAX`, 4, consecutive DM wins while IF is waiting before IF is forced to win; minimum 1

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_if_req`  in  1  IF request; held until `o_if_gnt`
- `i_if_addr`  in  ADDR_W  fetch address; stable while `i_if_req` is high
- `i_if_kill`  in  1  discard the response of any in-flight IF transaction (pipeline redirect)
- `o_if_gnt`  out  1  IF request accepted by memory
- `o_if_rvalid`  out  1  IF response valid
- `o_if_rdata`  out  DATA_W  fetched instruction
- `i_dm_req`  in  1  DM request; held until `o_dm_gnt`
- `i_dm_we`  in  1  1 = store, 0 = load
- `i_dm_addr`  in  ADDR_W  data address
- `i_dm_wdata`  in  DATA_W  store data
- `i_dm_be`  in  DATA_W/8  store byte enables
- `o_dm_gnt`  out  1  DM request accepted by memory
- `o_dm_rvalid`  out  1  DM response valid (load data or store acknowledge)
- `o_dm_rdata`  out  DATA_W  load data
- `o_mem_valid`  out  1  bus request valid
- `o_mem_we`  out  1  bus write enable
- `o_mem_addr`  out  ADDR_W  bus address
- `o_mem_wdata`  out  DATA_W  bus write data
- `o_mem_be`  out  DATA_W/8  bus byte enables; all ones for IF reads
- `i_mem_ready`  in  1  bus accepts the request
- `i_mem_rvalid`  in  1  bus response valid; returned for both reads and writes
- `i_mem_rdata`  in  DATA_W  bus read data

## Operation

Control is a three-state FSM: IDLE, REQ, RESP. Registered state: `owner` (IF/DM), `drop` flag, starvation counter `starve_cnt` (range 0..STARVE_MAX).

- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner:
    - DM wins if `i_dm_req` and (`!i_if_req` or `starve_cnt < STARVE_MAX`).
    - Else IF wins.
  - Register the winner's fields into `o_mem_*`; set `o_mem_valid`, `owner`, `drop=0`; go to REQ.
  - IF winner: `o_mem_we=0`, `o_mem_be` all ones, `o_mem_wdata=0`.
- **starve_cnt update** (on each IDLE decision)
  - DM wins while `i_if_req` is high: `starve_cnt+1`, saturating at STARVE_MAX.
  - IF wins, or `i_if_req` is low: reset to 0.
- **REQ**
  - `o_mem_*` is held stable and `o_mem_valid` stays high until `i_mem_ready`; it is never withdrawn.
  - In the `i_mem_ready` cycle, the owner's `o_*_gnt` is asserted combinationally: `state==REQ && i_mem_ready && owner==x`.
  - Then `o_mem_valid` clears and the FSM goes to RESP.
- **RESP**
  - Wait for `i_mem_rvalid`.
  - Next cycle, the owner's `o_*_rvalid` pulses for 1 cycle and `o_*_rdata` is the registered `i_mem_rdata`.
  - FSM returns to IDLE.
- **Kill**
  - `i_if_kill` high while `owner==IF` in REQ or RESP sets `drop`. The bus transaction still completes, but `o_if_rvalid` is suppressed.
  - `i_if_kill` in IDLE, or with `owner==DM`, has no effect.
- **Bus protocol errors**
  - `i_mem_rvalid` outside RESP is ignored.
  - `i_mem_ready` outside REQ is ignored.
- **Reset values**
  - State=IDLE, `starve_cnt=0`, `drop=0`, `owner=IF`.
  - All `o_*` valid/gnt/rvalid outputs are 0; all data/address outputs are 0.
  - Reset during REQ or RESP abandons the transaction: no gnt and no rvalid is produced for it.

## Timing

- Request sampled in IDLE at cycle N → `o_mem_valid` high at N+1.
- Grant in the cycle `i_mem_ready` is seen, at earliest N+1.
- `o_*_rvalid` is 1 cycle after `i_mem_rvalid`.
- Minimum transaction: N req, N+1 gnt (`ready=1`), N+2 `mem_rvalid`, N+3 `o_rvalid`, N+3 back in IDLE.
  - Best-case throughput is therefore one transaction per 3 cycles.
- A requester may drop or change its request in the cycle after its gnt.
- A request that is held but loses arbitration keeps its priority standing for the next IDLE cycle.
- A simultaneous IF and DM request in IDLE resolves per the priority and starvation rule in the same cycle.

## Test plan

- **Single IF read.** `i_if_req`, `addr=0x100`, `ready=1` immediately, `rdata=0x00500093` one cycle later.
  - Required: `o_mem_addr=0x100`, `be=0xF`, `we=0`; `o_if_gnt` one cycle; `o_if_rvalid` with `0x00500093` at N+3.
- **DM store with stalled bus.** `addr=0x2000`, `wdata=0xDEADBEEF`, `be=0x3`; `ready` low for 3 cycles.
  - Required: `o_mem_*` stable for all 4 cycles; `o_dm_gnt` only in the 4th; `o_dm_rvalid` after the write ack.
- **Simultaneous requests with both held continuously, `STARVE_MAX=4`.**
  - Required: grant order DM, DM, DM, DM, IF, then DM.
  - Required: `starve_cnt` returns to 0 after the IF grant.
- **IF kill.** Assert `i_if_kill` during RESP of an IF read.
  - Required: the bus response is consumed, `o_if_rvalid` stays 0, and the next IF request is serviced normally.
- **Reset mid-RESP**, followed by a spurious `i_mem_rvalid`.
  - Required: all outputs are 0 after reset and no rvalid is produced.
  - Required: a subsequent DM load at `0x40` returns correct data.
